vga_layer_pipe: RTL

- Parametrised pixel back-end for the VGA path. It does four things:
  - priority-composites N sprite/tile layer colour indices over a background index;
  - looks the winner up in a run-time writable dual-level palette;
  - applies a frame-alternating checkerboard dither;
  - blanks outside the active area.
- Successor to the fixed 8-layer / 27-colour / 1-bit output chain: it sits between the sprite engines and the DAC pins and aligns hsync/vsync with the pixel latency.

---
 rtl/vga_layer_pipe.sv | 118 +++++++++++
 1 files changed

// File: rtl/vga_layer_pipe.sv
// Layer compositor -> palette -> checkerboard dither -> blanking, with syncs delayed to match.
// Optional macro VGA_TKEY_EN: all-ones layer index is transparent (colour key).
module vga_layer_pipe #(
    parameter int       LAYERS    = 8,
    parameter int       CW        = 5,
    parameter int       BPC       = 1,
    parameter int       PHASE_BIT = 1,
    parameter logic     SYNC_RST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    input  logic [9:0]            cnt_x,
    input  logic [8:0]            cnt_y,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  de_in,
    input  logic                  splash,
    input  logic [LAYERS-1:0]     layer_hit,
    input  logic [LAYERS*CW-1:0]  layer_col,
    input  logic [CW-1:0]         bg_col,
    input  logic                  pal_we,
    input  logic [CW-1:0]         pal_addr,
    input  logic [6*BPC-1:0]      pal_wdata,
    output logic [BPC-1:0]        r,
    output logic [BPC-1:0]        g,
    output logic [BPC-1:0]        b,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_phase
);

    logic [6*BPC-1:0]   pal_mem [2**CW];

    logic [LAYERS-1:0]  opaque;
    logic [CW-1:0]      sel_idx;
    logic [CW-1:0]      s1_idx_q;
    logic               s1_x0_q, s1_y0_q, s2_x0_q, s2_y0_q;
    logic [2:0]         de_q, hs_q, vs_q;
    logic [6*BPC-1:0]   s2_col_q;
    logic [3*BPC-1:0]   s3_rgb_q, dith_d;
    logic               dith_k;
    logic [PHASE_BIT:0] fcnt_q, fcnt_d;

    always_comb begin
        opaque = layer_hit;
`ifdef VGA_TKEY_EN
        for (int i = 0; i < LAYERS; i++)
            if (layer_col[i*CW +: CW] == {CW{1'b1}}) opaque[i] = 1'b0;
`endif
    end

    // Scan from the lowest priority upward so layer 0 overwrites last and wins.
    always_comb begin
        sel_idx = bg_col;
        for (int i = LAYERS-1; i >= 0; i--)
            if (opaque[i]) sel_idx = layer_col[i*CW +: CW];
    end

    always_comb begin
        dith_k = s2_x0_q ^ s2_y0_q ^ ~frame_phase;
        if (dith_k)
            dith_d = {s2_col_q[6*BPC-1 -: BPC], s2_col_q[4*BPC-1 -: BPC], s2_col_q[2*BPC-1 -: BPC]};
        else
            dith_d = {s2_col_q[5*BPC-1 -: BPC], s2_col_q[3*BPC-1 -: BPC], s2_col_q[BPC-1:0]};
    end

    always_comb begin
        fcnt_d = fcnt_q;
        if (cnt_x == 10'd0 && cnt_y == 9'd0) fcnt_d = fcnt_q + (PHASE_BIT+1)'(1);
    end

    // Palette has no reset; a read and write to the same entry returns the old word.
    always_ff @(posedge clk) begin
        if (pal_we) pal_mem[pal_addr] <= pal_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_idx_q    <= '0;
            s1_x0_q     <= 1'b0;
            s1_y0_q     <= 1'b0;
            s2_x0_q     <= 1'b0;
            s2_y0_q     <= 1'b0;
            de_q        <= '0;
            hs_q        <= {3{SYNC_RST}};
            vs_q        <= {3{SYNC_RST}};
            s2_col_q    <= '0;
            s3_rgb_q    <= '0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            hsync       <= SYNC_RST;
            vsync       <= SYNC_RST;
            fcnt_q      <= '0;
            frame_phase <= 1'b0;
        end else if (pix_en) begin
            s1_idx_q    <= sel_idx;
            s1_x0_q     <= cnt_x[0];
            s1_y0_q     <= cnt_y[0];
            s2_x0_q     <= s1_x0_q;
            s2_y0_q     <= s1_y0_q;
            de_q        <= {de_q[1:0], de_in & splash};
            hs_q        <= {hs_q[1:0], hsync_in};
            vs_q        <= {vs_q[1:0], vsync_in};
            s2_col_q    <= pal_mem[s1_idx_q];
            s3_rgb_q    <= dith_d;
            r           <= de_q[2] ? s3_rgb_q[3*BPC-1 -: BPC] : '0;
            g           <= de_q[2] ? s3_rgb_q[2*BPC-1 -: BPC] : '0;
            b           <= de_q[2] ? s3_rgb_q[BPC-1:0]       : '0;
            hsync       <= hs_q[2];
            vsync       <= vs_q[2];
            fcnt_q      <= fcnt_d;
            frame_phase <= fcnt_d[PHASE_BIT];
        end
    end

endmodule
